// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM encoding,
// default bus widths and the opcode memory-class field.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LS_ACC = 2'd2
    } state_e;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    // Memory-class field of the instruction word, decoded upstream into ls_load/ls_store
    localparam int unsigned MCLASS_HI = 12;
    localparam int unsigned MCLASS_LO = 11;

    typedef enum logic [1:0] {
        MC_NONE     = 2'b00,
        MC_LOAD     = 2'b01,
        MC_STORE    = 2'b10,
        MC_LOAD_IMM = 2'b11
    } mem_class_e;

    function automatic logic is_mem_access(input mem_class_e mc);
        return (mc == MC_LOAD) || (mc == MC_STORE);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response signals plus the single-port memory
// handshake, bundled for the access controller.
interface mem_access_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              ls_load;
    logic              ls_store;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_done;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              err;

    modport slave (
        input  if_req, if_addr, ls_load, ls_store, ls_addr, ls_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, ls_rdata, ls_done, stall,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, ls_load, ls_store, ls_addr, ls_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, ls_rdata, ls_done, stall,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_ctrl_wdog.sv
// Ack timeout counter: cleared when an access is granted, counts cycles
// spent waiting for mem_ack and flags expiry on the TIMEOUT-th such cycle.
module mem_ctrl_wdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expire
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The count would reach TIMEOUT on this edge
    assign o_expire = i_run && (r_cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// Arbiter/sequencer for the shared single-port memory (load/store over fetch).
// Optional ack watchdog enabled by defining MEM_ACCESS_CTRL_WDOG_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);
    state_e            r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_ls_done;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_valid;
    logic              w_ls_any;

    assign w_ls_any = bus.ls_load | bus.ls_store;

`ifdef MEM_ACCESS_CTRL_WDOG_EN
    logic r_err;
    logic w_expire;

    mem_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    ((r_state == IDLE) && (w_ls_any || bus.if_req)),
        .i_run    ((r_state != IDLE) && !bus.mem_ack),
        .o_expire (w_expire)
    );
    assign bus.err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ls_rdata  <= '0;
            r_ls_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
`ifdef MEM_ACCESS_CTRL_WDOG_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_ls_done  <= 1'b0;
            r_if_valid <= 1'b0;
`ifdef MEM_ACCESS_CTRL_WDOG_EN
            r_err      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    // Store wins when both strobes are set
                    if (w_ls_any) begin
                        r_mem_addr  <= bus.ls_addr;
                        r_mem_wdata <= bus.ls_wdata;
                        r_mem_we    <= bus.ls_store;
                        r_mem_req   <= 1'b1;
                        r_state     <= LS_ACC;
                    end else if (bus.if_req) begin
                        r_mem_addr <= bus.if_addr;
                        r_mem_we   <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_state    <= IF_ACC;
                    end
                end
                IF_ACC, LS_ACC: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= IDLE;
                        if (r_state == LS_ACC) begin
                            r_ls_done <= 1'b1;
                            if (!r_mem_we) r_ls_rdata <= bus.mem_rdata;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                    end
`ifdef MEM_ACCESS_CTRL_WDOG_EN
                    else if (w_expire) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= IDLE;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.ls_done   = r_ls_done;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.stall     = (w_ls_any & ~r_ls_done) | (bus.if_req & ~r_if_valid);
endmodule
